// File: rtl/scc_chk_pkg.sv
// Shared types and defaults for the result checker.
// Holds the FSM state encoding and parameter defaults.
package scc_chk_pkg;

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_REQ,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  localparam int DEF_NUM_CHECKS     = 2;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 100000;
  localparam int DEF_DRAIN_CYCLES   = 1;
  localparam int DEF_ACK_TIMEOUT    = 15;
  localparam int CNT_W              = 32;

endpackage

// File: rtl/scc_cycle_counter.sv
// Saturating enabled counter with terminal-count flag.
// Ports: clk, rst (async low), clr, inc, limit -> count, tc.
module scc_cycle_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/scc_result_checker.sv
// End-of-run result checker: waits for halt, reads back and compares.
// Ports: clk/rst/clk_en, halt_f, exp_*, rd_* bus, status outputs.
module scc_result_checker
  import scc_chk_pkg::*;
#(
  parameter int NUM_CHECKS     = DEF_NUM_CHECKS,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     halt_f,
  input  logic [NUM_CHECKS*DATA_W-1:0] exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
  output logic                     rd_req,
  output logic [DATA_W-1:0]        rd_addr,
  input  logic                     rd_ack,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     done,
  output logic                     pass,
  output logic [NUM_CHECKS-1:0]    fail_mask,
  output logic                     timed_out,
  output logic                     bus_err,
  output logic [31:0]              cycles
);

  localparam int IW =
    (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0] TO_LIM =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DR_LIM =
    CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LIM =
    CNT_W'(ACK_TIMEOUT - 1);

  state_t            state;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     nidx;
  logic [DATA_W-1:0] rdata;
  logic              mism;
  logic              cyc_inc;
  logic              cyc_tc;
  logic              w_clr;
  logic              w_inc;
  logic              w_tc;
  logic [CNT_W-1:0]  w_lim;
  logic [CNT_W-1:0]  wcnt_unused;

  assign nidx = idx + IW'(1);
  assign mism =
    rdata != exp_data[idx*DATA_W +: DATA_W];

  // Only RUN cycles without halt are counted.
  assign cyc_inc =
    clk_en && (state == S_RUN) && !halt_f;

  // One counter serves drain and ack wait;
  // it is zero on entry to either state.
  assign w_clr = clk_en &&
    (state != S_DRAIN) && (state != S_WAIT);
  assign w_inc = clk_en &&
    ((state == S_DRAIN) ||
     ((state == S_WAIT) && !rd_ack));
  assign w_lim =
    (state == S_DRAIN) ? DR_LIM : ACK_LIM;

  scc_cycle_counter #(.W(CNT_W)) u_cyc (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (cyc_inc),
    .limit (TO_LIM),
    .count (cycles),
    .tc    (cyc_tc)
  );

  scc_cycle_counter #(.W(CNT_W)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .inc   (w_inc),
    .limit (w_lim),
    .count (wcnt_unused),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RUN;
      idx       <= '0;
      rdata     <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      timed_out <= 1'b0;
      bus_err   <= 1'b0;
    end else if (clk_en) begin
      unique case (state)
        S_RUN: begin
          if (halt_f) begin
            state <= S_DRAIN;
          end else if (cyc_tc) begin
            timed_out <= 1'b1;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_tc) begin
            idx     <= '0;
            rd_req  <= 1'b1;
            rd_addr <= exp_addr[0 +: DATA_W];
            state   <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (rd_ack) begin
            rdata  <= rd_data;
            rd_req <= 1'b0;
            state  <= S_CMP;
          end else if (w_tc) begin
            bus_err   <= 1'b1;
            fail_mask <= '1;
            rd_req    <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_CMP: begin
          if (mism)
            fail_mask[idx] <= 1'b1;
          if (idx == LAST) begin
            done  <= 1'b1;
            pass  <= !mism && (fail_mask == '0) &&
                     !timed_out;
            state <= S_DONE;
          end else begin
            idx     <= nidx;
            rd_req  <= 1'b1;
            rd_addr <= exp_addr[nidx*DATA_W +: DATA_W];
            state   <= S_REQ;
          end
        end
        S_DONE: state <= S_DONE;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_scc_result_checker.sv
// Randomized self-checking bench for scc_result_checker.
// Two instances (2 and 4 checks) share control inputs.
module tb_scc_result_checker;

  localparam int TO = 200;
  localparam int AT = 15;
  localparam int NONE = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        halt_f;
  logic [63:0]  ea0, ed0;
  logic [127:0] ea1, ed1;
  logic [1:0]  rd_req, rd_ack, done, pass, tmo, berr;
  logic [31:0] rd_addr [2];
  logic [31:0] rd_data [2];
  logic [31:0] cyc [2];
  logic [1:0]  fm0;
  logic [3:0]  fm1;

  int n_chk = 0;
  int n_fail = 0;

  int halt_at;
  bit toggle;
  int dmin, dmax;
  int mis [2];
  int noack [2];
  logic [31:0] xv [2];
  bit stray;

  int en_cnt;
  bit prev_req [2];
  int seen [2];
  int dly [2];
  int req_cnt [2];
  bit acked [2];

  logic [3:0] e_fm [2];
  bit e_pass [2];
  bit e_to [2];
  bit e_be [2];
  int e_cyc;
  int e_reqs [2];

  bit cdone [2];
  bit creq [2];
  logic [31:0] caddr [2];

  always #5 clk = ~clk;

  scc_result_checker #(
    .NUM_CHECKS(2), .DATA_W(32),
    .TIMEOUT_CYCLES(TO), .DRAIN_CYCLES(1),
    .ACK_TIMEOUT(AT)
  ) dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .halt_f(halt_f),
    .exp_addr(ea0), .exp_data(ed0),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]),
    .rd_ack(rd_ack[0]), .rd_data(rd_data[0]),
    .done(done[0]), .pass(pass[0]),
    .fail_mask(fm0), .timed_out(tmo[0]),
    .bus_err(berr[0]), .cycles(cyc[0])
  );

  scc_result_checker #(
    .NUM_CHECKS(4), .DATA_W(32),
    .TIMEOUT_CYCLES(TO), .DRAIN_CYCLES(1),
    .ACK_TIMEOUT(AT)
  ) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .halt_f(halt_f),
    .exp_addr(ea1), .exp_data(ed1),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]),
    .rd_ack(rd_ack[1]), .rd_data(rd_data[1]),
    .done(done[1]), .pass(pass[1]),
    .fail_mask(fm1), .timed_out(tmo[1]),
    .bus_err(berr[1]), .cycles(cyc[1])
  );

  function automatic int nchk(int u);
    return (u == 0) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_a(int u, int k);
    if (k >= nchk(u)) return 32'hdead_beef;
    return (u == 0) ? ea0[k*32 +: 32] : ea1[k*32 +: 32];
  endfunction

  function automatic logic [31:0] exp_d(int u, int k);
    return (u == 0) ? ed0[k*32 +: 32] : ed1[k*32 +: 32];
  endfunction

  function automatic logic [3:0] fmask(int u);
    return (u == 0) ? {2'b00, fm0} : fm1;
  endfunction

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Per-cycle compare against the scenario model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        cdone[u] = 1'b0;
        creq[u]  = 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d_pass_gated", u),
            pass[u] & ~done[u], 0);
        if (cdone[u])
          chk($sformatf("u%0d_done_sticky", u), done[u], 1);
        if (creq[u] && rd_req[u])
          chk($sformatf("u%0d_addr_stable", u),
              rd_addr[u], caddr[u]);
        if (done[u] && !cdone[u]) begin
          chk($sformatf("u%0d_pass", u), pass[u], e_pass[u]);
          chk($sformatf("u%0d_fail_mask", u),
              fmask(u), e_fm[u]);
          chk($sformatf("u%0d_timed_out", u), tmo[u], e_to[u]);
          chk($sformatf("u%0d_bus_err", u), berr[u], e_be[u]);
          chk($sformatf("u%0d_cycles", u), cyc[u], e_cyc);
          chk($sformatf("u%0d_reads", u),
              req_cnt[u], e_reqs[u]);
          chk($sformatf("u%0d_req_idle", u), rd_req[u], 0);
        end
        cdone[u] = done[u];
        creq[u]  = rd_req[u];
        caddr[u] = rd_addr[u];
      end
    end
  end

  // One clock of stimulus plus the memory responder.
  task automatic cycle();
    int k;
    clk_en = toggle ? ($urandom_range(0, 2) != 0) : 1'b1;
    halt_f = (en_cnt >= halt_at);
    for (int u = 0; u < 2; u++) begin
      k = req_cnt[u] - 1;
      rd_ack[u]  = 1'b0;
      rd_data[u] = $urandom;
      if (stray) begin
        rd_ack[u] = 1'b1;
      end else if (rd_req[u] && !acked[u] && clk_en &&
                   seen[u] >= 1 + dly[u] &&
                   k != noack[u]) begin
        rd_ack[u]  = 1'b1;
        rd_data[u] = exp_d(u, k) ^
                     ((k == mis[u]) ? xv[u] : 32'h0);
      end
    end
    stray = 1'b0;
    @(posedge clk);
    #1;
    if (clk_en) en_cnt++;
    for (int u = 0; u < 2; u++) begin
      if (rd_ack[u] && clk_en) acked[u] = 1'b1;
      if (prev_req[u] && clk_en) seen[u]++;
      if (rd_req[u] && !prev_req[u]) begin
        chk($sformatf("u%0d_addr_order%0d", u, req_cnt[u]),
            rd_addr[u], exp_a(u, req_cnt[u]));
        req_cnt[u]++;
        seen[u]  = 0;
        acked[u] = 1'b0;
        dly[u]   = $urandom_range(dmin, dmax);
      end
      if (prev_req[u] && !rd_req[u] &&
          req_cnt[u] - 1 == noack[u])
        chk($sformatf("u%0d_ack_wait_len", u),
            seen[u], 1 + AT);
      prev_req[u] = rd_req[u];
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++)
      chk($sformatf("u%0d_reset_state", u),
          {rd_req[u], rd_addr[u], done[u], pass[u],
           fmask(u), tmo[u], berr[u], cyc[u]}, 0);
    en_cnt = 0;
    rd_ack = 2'b00;
    clk_en = 1'b0;
    halt_f = 1'b0;
    for (int u = 0; u < 2; u++) begin
      prev_req[u] = 1'b0;
      seen[u]     = 0;
      req_cnt[u]  = 0;
      acked[u]    = 1'b0;
    end
    @(posedge clk);
    #1;
    rst   = 1'b1;
    stray = 1'b1;
  endtask

  task automatic setup(int h, bit tg, int d0, int d1,
                       int m0, int m1, int n0, int n1,
                       logic [31:0] x0);
    halt_at = h; toggle = tg; dmin = d0; dmax = d1;
    mis[0] = m0; mis[1] = m1;
    noack[0] = n0; noack[1] = n1;
    xv[0] = x0;
    xv[1] = $urandom | 32'h1;
    e_to[0] = (h >= TO);
    e_to[1] = e_to[0];
    e_cyc   = e_to[0] ? TO : h;
    for (int u = 0; u < 2; u++) begin
      e_be[u] = noack[u] < nchk(u);
      if (e_be[u])
        e_fm[u] = (u == 0) ? 4'h3 : 4'hf;
      else if (mis[u] < nchk(u))
        e_fm[u] = 4'(1 << mis[u]);
      else
        e_fm[u] = 4'h0;
      e_pass[u] = !e_be[u] && e_fm[u] == 0 && !e_to[u];
      e_reqs[u] = e_be[u] ? noack[u] + 1 : nchk(u);
    end
  endtask

  task automatic run_to_done(string nm);
    int n = 0;
    while (!(done[0] && done[1]) && n < 5000) begin
      cycle();
      n++;
    end
    chk({nm, "_finished"}, done, 2'b11);
    repeat (3) cycle();
  endtask

  task automatic rand_exp();
    ea1 = {$urandom, $urandom, $urandom, $urandom};
    ed1 = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1;
    stray = 1'b0;
    ea0 = {32'h408, 32'h404};
    ed0 = {32'h39, 32'h40};
    rand_exp();
    setup(50, 0, 0, 0, NONE, NONE, NONE, NONE, 32'h1);
    #2;

    do_reset();
    setup(50, 0, 0, 3, NONE, NONE, NONE, NONE, 32'h1);
    run_to_done("match");
    chk("match_cycles_lit", cyc[0], 50);
    chk("match_mask_lit", fm0, 2'b00);
    chk("match_pass_lit", pass[0], 1);

    do_reset();
    rand_exp();
    setup(50, 0, 0, 3, 1, $urandom_range(0, 3),
          NONE, NONE, 32'h1);
    run_to_done("mismatch");
    chk("mismatch_mask_lit", fm0, 2'b10);
    chk("mismatch_pass_lit", pass[0], 0);

    do_reset();
    rand_exp();
    setup(100000, 0, 0, 3, NONE, NONE, NONE, NONE, 32'h1);
    run_to_done("timeout");
    chk("timeout_flag_lit", tmo[0], 1);
    chk("timeout_cycles_lit", cyc[0], TO);
    chk("timeout_pass_lit", pass[0], 0);

    do_reset();
    rand_exp();
    setup(50, 0, 0, 3, NONE, NONE, 1,
          $urandom_range(0, 3), 32'h1);
    run_to_done("noack");
    chk("noack_buserr_lit", berr[0], 1);
    chk("noack_mask_lit", fm0, 2'b11);
    chk("noack_pass_lit", pass[0], 0);

    do_reset();
    rand_exp();
    setup($urandom_range(10, 150), 1, 0, 5,
          NONE, NONE, NONE, NONE, 32'h1);
    run_to_done("toggle");
    chk("toggle_pass_lit", pass[1], 1);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      rand_exp();
      setup($urandom_range(0, 250), 1, 0, 5,
            $urandom_range(0, 5), $urandom_range(0, 5),
            ($urandom_range(0, 3) == 0) ? 1 : NONE,
            ($urandom_range(0, 3) == 0) ?
              int'($urandom_range(0, 3)) : NONE,
            $urandom | 32'h1);
      run_to_done($sformatf("rand%0d", i));
    end

    // Reset pulse while check 0 is waiting for its ack.
    do_reset();
    setup(20, 0, 8, 8, NONE, NONE, NONE, NONE, 32'h1);
    begin
      int n = 0;
      while (!(rd_req[0] && seen[0] >= 2) && n < 500) begin
        cycle();
        n++;
      end
      chk("rst_reach_wait", rd_req[0] && seen[0] >= 2, 1);
    end
    #2;
    do_reset();
    setup(20, 0, 0, 3, NONE, NONE, NONE, NONE, 32'h1);
    run_to_done("rerun");
    chk("rerun_pass_lit", pass[0], 1);
    chk("rerun_cycles_lit", cyc[0], 20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
